// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the sysid slave (ID, then timestamp) and reports pass/fail.
// Optional timestamp read is enabled by defining SYSID_CHECK_TIMESTAMP_EN.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1461568625,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_mm_q, id_mm_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_val_q, id_val_d;
  logic [15:0] stall_q, stall_d;
  logic        complete, expire, go;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  logic        ts_mm_q, ts_mm_d;
  logic [31:0] ts_val_q, ts_val_d;
`endif

  assign complete = read_q & ~waitrequest;
  assign expire   = (TMO_LIMIT != 16'd0) && read_q && waitrequest &&
                    ((stall_q + 16'd1) == TMO_LIMIT);
  // first_q is only high on the first cycle after reset release
  assign go       = start | (first_q & AUTO_START);

  always_comb begin
    state_d  = state_q;
    first_d  = 1'b0;
    read_d   = read_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    id_mm_d  = id_mm_q;
    tmo_d    = tmo_q;
    id_val_d = id_val_q;
    stall_d  = (read_q & waitrequest) ? stall_q + 16'd1 : stall_q;
`ifdef SYSID_CHECK_TIMESTAMP_EN
    ts_mm_d  = ts_mm_q;
    ts_val_d = ts_val_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d  = RD_ID;
          read_d   = 1'b1;
          addr_d   = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          id_mm_d  = 1'b0;
          tmo_d    = 1'b0;
          id_val_d = 32'd0;
          stall_d  = 16'd0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
          ts_mm_d  = 1'b0;
          ts_val_d = 32'd0;
`endif
        end
      end
      RD_ID: begin
        if (expire) begin
          state_d = DONE;
          read_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
          stall_d = 16'd0;
        end else if (complete) begin
          id_val_d = readdata;
          id_mm_d  = (readdata != EXPECTED_ID);
          read_d   = 1'b0;
          stall_d  = 16'd0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
          state_d  = RD_TS;
`else
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = (readdata == EXPECTED_ID);
`endif
        end
      end
`ifdef SYSID_CHECK_TIMESTAMP_EN
      RD_TS: begin
        // read_q low here is the mandatory idle cycle after the ID read
        if (!read_q) begin
          read_d = 1'b1;
          addr_d = 1'b1;
        end else if (expire) begin
          state_d = DONE;
          read_d  = 1'b0;
          addr_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
          stall_d = 16'd0;
        end else if (complete) begin
          ts_val_d = readdata;
          ts_mm_d  = (readdata != EXPECTED_TIMESTAMP);
          state_d  = DONE;
          read_d   = 1'b0;
          addr_d   = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = ~id_mm_q & (readdata == EXPECTED_TIMESTAMP);
          stall_d  = 16'd0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      first_q  <= 1'b1;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      id_mm_q  <= 1'b0;
      tmo_q    <= 1'b0;
      id_val_q <= 32'd0;
      stall_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      id_mm_q  <= id_mm_d;
      tmo_q    <= tmo_d;
      id_val_q <= id_val_d;
      stall_q  <= stall_d;
    end
  end

`ifdef SYSID_CHECK_TIMESTAMP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_mm_q  <= 1'b0;
      ts_val_q <= 32'd0;
    end else begin
      ts_mm_q  <= ts_mm_d;
      ts_val_q <= ts_val_d;
    end
  end
  assign ts_mismatch = ts_mm_q;
  assign ts_value    = ts_val_q;
`else
  assign ts_mismatch = 1'b0;
  assign ts_value    = 32'd0;
`endif

  assign address     = addr_q;
  assign read        = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign timeout     = tmo_q;
  assign id_value    = id_val_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker with a behavioural sysid slave (programmable stall).
module tb_sysid_boot_checker;

`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int          LAT    = TS_EN ? 4 : 2;
  localparam int          LAT3   = TS_EN ? 10 : 5;
  localparam int          NREADS = TS_EN ? 2 : 1;
  localparam logic [31:0] GOOD_TS = 32'd1461568625;
  localparam logic [31:0] EXP_TS  = TS_EN ? GOOD_TS : 32'd0;
  localparam logic [1:0]  EXP_HIST = TS_EN ? 2'b01 : 2'b00;

  logic        clk = 1'b0;
  logic        reset, start, address, read, waitrequest;
  logic [31:0] readdata, id_value, ts_value;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;

  logic [31:0] id_word, ts_word;
  int          stall_n;
  logic        stuck;
  int          wait_cnt = 0;
  int          rd_cnt   = 0;
  int          a1_cnt   = 0;
  logic [7:0]  hist     = 8'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int base, a1base;

  always #5 clk = ~clk;

  sysid_boot_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(GOOD_TS),
    .TIMEOUT_CYCLES    (8),
    .AUTO_START        (1'b1)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .address    (address),
    .read       (read),
    .waitrequest(waitrequest),
    .readdata   (readdata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch),
    .timeout    (timeout),
    .id_value   (id_value),
    .ts_value   (ts_value)
  );

  // Slave: stalls each read for stall_n cycles (or forever when stuck), latency 0
  assign waitrequest = stuck | (read && (wait_cnt < stall_n));
  assign readdata    = address ? ts_word : id_word;

  always @(posedge clk) begin
    if (reset || !read) begin
      wait_cnt <= 0;
    end else if (waitrequest) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      rd_cnt   <= rd_cnt + 1;
      hist     <= {hist[6:0], address};
    end
    if (read && address) a1_cnt <= a1_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall_n = 0; stuck = 1'b0;
    id_word = 32'd0; ts_word = GOOD_TS;
    step(3);
    check("rst_flags", {24'd0, read, address, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", ts_value, 32'd0);

    // Auto-start after reset release
    base = rd_cnt;
    reset = 1'b0;
    step(1);
    check("auto_read", {31'd0, read}, 32'd1);
    check("auto_addr", {31'd0, address}, 32'd0);
    check("auto_busy", {31'd0, busy}, 32'd1);
    step(LAT - 2);
    check("auto_done_early", {31'd0, done}, 32'd0);
    step(1);
    check("auto_done", {31'd0, done}, 32'd1);
    check("auto_pass", {31'd0, pass}, 32'd1);
    check("auto_busy_off", {31'd0, busy}, 32'd0);
    check("auto_id_value", id_value, 32'd0);
    check("auto_ts_value", ts_value, EXP_TS);
    check("auto_nreads", rd_cnt - base, NREADS);
    check("auto_addr_order", {30'd0, hist[1:0]}, {30'd0, EXP_HIST});

    // ID mismatch
    id_word = 32'h0000_0001;
    start = 1'b1; step(1); start = 1'b0;
    step(LAT - 1);
    check("mm_done", {31'd0, done}, 32'd1);
    check("mm_id_mismatch", {31'd0, id_mismatch}, 32'd1);
    check("mm_ts_mismatch", {31'd0, ts_mismatch}, 32'd0);
    check("mm_pass", {31'd0, pass}, 32'd0);
    check("mm_id_value", id_value, 32'h0000_0001);

    // Re-run from DONE clears flags; start while busy is ignored
    id_word = 32'd0;
    base = rd_cnt;
    start = 1'b1; step(1); start = 1'b0;
    check("rr_done_clr", {31'd0, done}, 32'd0);
    check("rr_mm_clr", {31'd0, id_mismatch}, 32'd0);
    check("rr_id_clr", id_value, 32'd0);
    check("rr_busy", {31'd0, busy}, 32'd1);
`ifdef SYSID_CHECK_TIMESTAMP_EN
    step(1);
    start = 1'b1;
    check("rr_gap_read", {31'd0, read}, 32'd0);
    step(1); start = 1'b0;
    step(1);
`else
    start = 1'b1;
    step(1); start = 1'b0;
`endif
    check("rr_done", {31'd0, done}, 32'd1);
    check("rr_pass", {31'd0, pass}, 32'd1);
    step(3);
    check("rr_no_rerun_read", {31'd0, read}, 32'd0);
    check("rr_no_rerun_done", {31'd0, done}, 32'd1);
    check("rr_nreads", rd_cnt - base, NREADS);

    // Three stall cycles on each read
    stall_n = 3;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 1; i < LAT3; i++) begin
      check($sformatf("st_read_c%0d", i), {31'd0, read},
            {31'd0, (i <= 4) || (TS_EN && i >= 6 && i <= 9)});
      check($sformatf("st_addr_c%0d", i), {31'd0, address}, {31'd0, TS_EN && i >= 6});
      check($sformatf("st_done_c%0d", i), {31'd0, done}, 32'd0);
      step(1);
    end
    check("st_done", {31'd0, done}, 32'd1);
    check("st_pass", {31'd0, pass}, 32'd1);
    stall_n = 0;

    // Stuck slave with TIMEOUT_CYCLES=8
    stuck = 1'b1;
    a1base = a1_cnt;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("to_read_c%0d", i), {31'd0, read}, 32'd1);
      step(1);
    end
    check("to_read_drop", {31'd0, read}, 32'd0);
    check("to_timeout", {31'd0, timeout}, 32'd1);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_pass", {31'd0, pass}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_no_addr1", a1_cnt - a1base, 32'd0);
    stuck = 1'b0;

    // Reset asserted during a stalled ID read
    stall_n = 3;
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    check("rm_read_before", {31'd0, read}, 32'd1);
    reset = 1'b1;
    #1;
    check("rm_flags", {24'd0, read, address, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
    check("rm_values", id_value | ts_value, 32'd0);
    stall_n = 0;
    step(1);
    reset = 1'b0;
    step(LAT);
    check("rm_done", {31'd0, done}, 32'd1);
    check("rm_pass", {31'd0, pass}, 32'd1);
    check("rm_ts_value", ts_value, EXP_TS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
